// File: rtl/hs_pkg.sv
// Shared helpers for the hs_pipe valid/ready register pipeline.
package hs_pkg;

  // Occupancy counter width for a chain of `stages` two-entry skid slices.
  function automatic int hs_cnt_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/hs_skid_slice.sv
// One skid-buffer slice: a main output register plus a skid register.
// in_ready comes straight from the skid flag, so it never depends on out_ready in the same cycle.
module hs_skid_slice import hs_pkg::*; #(
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] main_data, skid_data;
  logic              main_valid, skid_valid;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_data  <= '0;
      skid_data  <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      // NOTE: flush clears only the valid flags; the data registers keep
      // their contents because nothing can observe them while invalid.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      // Main register is free this edge: refill from skid first to keep FIFO order.
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_valid;
        if (in_valid) main_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/hs_pipe.sv
// Valid/ready pipeline of STAGES skid slices with occupancy count and synchronous flush.
module hs_pipe import hs_pkg::*; #(
  parameter  int DATA_W = 7,
  parameter  int STAGES = 2,
  localparam int CNT_W  = hs_cnt_w(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  occupancy
);

  localparam logic [CNT_W-1:0] MAX_OCC = CNT_W'(2 * STAGES);

  // Index i is the boundary feeding slice i; index STAGES is the pipeline output.
  logic [DATA_W-1:0] chain_data  [STAGES+1];
  logic              chain_valid [STAGES+1];
  logic              chain_ready [STAGES+1];

  assign chain_data[0]       = s_data;
  assign chain_valid[0]      = s_valid;
  assign chain_ready[STAGES] = m_ready && !flush;

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    hs_skid_slice #(.DATA_W(DATA_W)) u_slice (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_data   (chain_data[i]),
      .in_valid  (chain_valid[i]),
      .in_ready  (chain_ready[i]),
      .out_data  (chain_data[i+1]),
      .out_valid (chain_valid[i+1]),
      .out_ready (chain_ready[i+1])
    );
  end

  // Flush blocks both boundaries in its own cycle so no word crosses while being discarded.
  assign s_ready = chain_ready[0] && !flush;
  assign m_valid = chain_valid[STAGES] && !flush;
  assign m_data  = chain_data[STAGES];

  logic in_fire, out_fire;
  assign in_fire  = s_valid && s_ready;
  assign out_fire = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + CNT_W'(1);
    end else if (out_fire && !in_fire) begin
      occupancy <= occupancy - CNT_W'(1);
    end
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst) occupancy <= MAX_OCC);

endmodule

// File: tb/tb_hs_pipe.sv
// Scoreboard bench for hs_pipe: directed vectors on a DATA_W=7/STAGES=2 instance,
// plus random-stall runs on DATA_W=16/STAGES=1 and DATA_W=7/STAGES=3 instances.
module tb_hs_pipe;

  localparam int DW = 7;
  localparam int ST = 2;
  localparam int CW = $clog2(2 * ST + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data;
  logic [CW-1:0] occupancy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];

  hs_pipe #(.DATA_W(DW), .STAGES(ST)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .occupancy (occupancy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; the queue tracks words the DUT accepts at the next rising edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic mr, input logic fl);
    @(negedge clk);
    s_valid = v;
    s_data  = d;
    m_ready = mr;
    flush   = fl;
    #1;
    if (fl) q.delete();
    else if (s_valid && s_ready) q.push_back(s_data);
  endtask

  // Monitor for the directed instance.
  initial begin : mon
    logic          stalled;
    logic [DW-1:0] held, exp;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      check("occ_vs_queue", 32'(occupancy), q.size());
      #2;
      if (rst && !flush) begin
        if (stalled) begin
          check("hold_valid", 32'(m_valid), 1);
          check("hold_data", 32'(m_data), 32'(held));
        end
        if (m_valid && m_ready) begin
          check("queue_nonempty", 32'(q.size() != 0), 1);
          if (q.size() != 0) begin
            exp = q.pop_front();
            check("out_data", 32'(m_data), 32'(exp));
          end
        end
      end
      stalled = m_valid && !m_ready;
      held    = m_data;
    end
  end

  // Random-stall instances with their own driver and monitor.
  for (genvar k = 0; k < 2; k++) begin : g_rand
    localparam int RDW = (k == 0) ? 16 : 7;
    localparam int RST = (k == 0) ? 1 : 3;
    localparam int RCW = $clog2(2 * RST + 1);

    logic           r_rst, r_flush, r_sv, r_sr, r_mv, r_mr, done;
    logic [RDW-1:0] r_sd, r_md;
    logic [RCW-1:0] r_occ;
    logic [RDW-1:0] rq[$];

    hs_pipe #(.DATA_W(RDW), .STAGES(RST)) u_rdut (
      .clk       (clk),
      .rst       (r_rst),
      .flush     (r_flush),
      .s_data    (r_sd),
      .s_valid   (r_sv),
      .s_ready   (r_sr),
      .m_data    (r_md),
      .m_valid   (r_mv),
      .m_ready   (r_mr),
      .occupancy (r_occ)
    );

    initial begin : rdrv
      done    = 1'b0;
      r_rst   = 1'b0;
      r_flush = 1'b0;
      r_sv    = 1'b0;
      r_sd    = '0;
      r_mr    = 1'b0;
      repeat (3) @(negedge clk);
      r_rst = 1'b1;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        r_sv = 1'($urandom_range(0, 1));
        r_sd = RDW'($urandom);
        r_mr = 1'($urandom_range(0, 1));
        #1;
        if (r_sv && r_sr) rq.push_back(r_sd);
      end
      @(negedge clk);
      r_sv = 1'b0;
      r_mr = 1'b1;
      repeat (2 * RST + 3) @(negedge clk);
      check("rand_drained", 32'(r_occ), 0);
      done = 1'b1;
    end

    initial begin : rmon
      logic           stalled;
      logic [RDW-1:0] held, exp;
      stalled = 1'b0;
      held    = '0;
      forever begin
        @(negedge clk);
        check("rand_occ_vs_queue", 32'(r_occ), rq.size());
        #2;
        if (r_rst) begin
          if (stalled) begin
            check("rand_hold_valid", 32'(r_mv), 1);
            check("rand_hold_data", 32'(r_md), 32'(held));
          end
          if (r_mv && r_mr) begin
            check("rand_queue_nonempty", 32'(rq.size() != 0), 1);
            if (rq.size() != 0) begin
              exp = rq.pop_front();
              check("rand_out_data", 32'(r_md), 32'(exp));
            end
          end
        end
        stalled = r_mv && !r_mr;
        held    = r_md;
      end
    end
  end

  initial begin : drv
    rst     = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 1);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_occ", 32'(occupancy), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_s_ready", 32'(s_ready), 1);
    check("post_rst_m_valid", 32'(m_valid), 0);

    // Streaming 0x01..0x10 with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, DW'(i + 1), 1'b1, 1'b0);
      check("stream_s_ready", 32'(s_ready), 1);
      if (i == 1) check("lat_not_yet", 32'(m_valid), 0);
      if (i == 2) begin
        check("lat_valid", 32'(m_valid), 1);
        check("lat_data", 32'(m_data), 32'h01);
      end
      if (i >= 2) check("stream_b2b", 32'(m_valid), 1);
      if (i == 8) check("stream_occ", 32'(occupancy), 2);
    end
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // Fill with backpressure: only four of 0x11..0x15 fit.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(7'h11 + i), 1'b0, 1'b0);
      if (i == 3) check("fill_s_ready_3", 32'(s_ready), 1);
      if (i == 4) begin
        check("full_s_ready", 32'(s_ready), 0);
        check("full_occ", 32'(occupancy), 4);
      end
    end
    // Consumer resumes while producer keeps offering 0x15.
    step(1'b1, 7'h15, 1'b1, 1'b0);
    check("sim_full_s_ready", 32'(s_ready), 0);
    check("sim_full_m_valid", 32'(m_valid), 1);
    step(1'b1, 7'h15, 1'b1, 1'b0);
    check("sim_occ_3", 32'(occupancy), 3);
    check("sim_s_ready_1cyc", 32'(s_ready), 0);
    step(1'b1, 7'h15, 1'b1, 1'b0);
    check("sim_s_ready_2cyc", 32'(s_ready), 1);
    check("sim_occ_2", 32'(occupancy), 2);
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);

    // Flush with three words held.
    step(1'b1, 7'h21, 1'b0, 1'b0);
    step(1'b1, 7'h22, 1'b0, 1'b0);
    step(1'b1, 7'h23, 1'b0, 1'b0);
    step(1'b1, 7'h24, 1'b1, 1'b1);
    check("flush_occ_before", 32'(occupancy), 3);
    check("flush_s_ready", 32'(s_ready), 0);
    check("flush_m_valid", 32'(m_valid), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_flush_occ", 32'(occupancy), 0);
    check("post_flush_m_valid", 32'(m_valid), 0);
    check("post_flush_s_ready", 32'(s_ready), 1);
    step(1'b1, 7'h2A, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_2a_early", 32'(m_valid), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_2a_valid", 32'(m_valid), 1);
    check("flush_2a_data", 32'(m_data), 32'h2A);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // Reset in the middle of traffic.
    step(1'b1, 7'h31, 1'b0, 1'b0);
    step(1'b1, 7'h32, 1'b0, 1'b0);
    step(1'b1, 7'h33, 1'b0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    rst = 1'b0;
    q.delete();
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 0);
    check("mid_rst_occ", 32'(occupancy), 0);
    check("mid_rst_m_data", 32'(m_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_rel_s_ready", 32'(s_ready), 1);
    check("mid_rst_rel_m_valid", 32'(m_valid), 0);
    step(1'b1, 7'h3C, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    check("final_occ", 32'(occupancy), 0);

    for (int c = 0; c < 3000 && !(g_rand[0].done && g_rand[1].done); c++) @(negedge clk);
    check("rand_finished", 32'(g_rand[0].done && g_rand[1].done), 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
